// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle HI/LO divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Leading-zero skip sizes, largest first.
  localparam int unsigned SKIP_L = 16;
  localparam int unsigned SKIP_M = 8;
  localparam int unsigned SKIP_S = 4;

  // Width of a counter that must hold the value WIDTH.
  function automatic int unsigned cnt_width(input int unsigned width);
    return 32'($clog2(width)) + 32'd1;
  endfunction

endpackage

// File: rtl/div_radix4_step.sv
// One radix-4 restoring step: picks the largest multiple of |B| (0..3) not
// exceeding 4*rem + next two dividend bits and subtracts it.
module div_radix4_step #(
  parameter int unsigned REMW = 34
) (
  input  logic [REMW-1:0] i_rem,
  input  logic [1:0]      i_bits,
  input  logic [REMW-1:0] i_b1,
  input  logic [REMW-1:0] i_b2,
  input  logic [REMW-1:0] i_b3,
  output logic [REMW-1:0] o_rem_c,
  output logic [1:0]      o_digit_c
);

  logic [REMW-1:0] w_p;
  logic [REMW:0]   w_d1;
  logic [REMW:0]   w_d2;
  logic [REMW:0]   w_d3;

  // rem < |B| < 2^(REMW-2), so dropping the top two bits loses nothing.
  assign w_p  = REMW'({i_rem, i_bits});
  assign w_d1 = {1'b0, w_p} - {1'b0, i_b1};
  assign w_d2 = {1'b0, w_p} - {1'b0, i_b2};
  assign w_d3 = {1'b0, w_p} - {1'b0, i_b3};

  // Digit select: the MSB of each difference is the borrow.
  always_comb begin
    o_rem_c   = w_p;
    o_digit_c = 2'd0;
    if (!w_d3[REMW]) begin
      o_rem_c   = REMW'(w_d3);
      o_digit_c = 2'd3;
    end else if (!w_d2[REMW]) begin
      o_rem_c   = REMW'(w_d2);
      o_digit_c = 2'd2;
    end else if (!w_d1[REMW]) begin
      o_rem_c   = REMW'(w_d1);
      o_digit_c = 2'd1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider with HI/LO result registers,
// leading-zero skip, flush and MTHI/MTLO writes.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned EARLY_SKIP = 1
) (
  input  logic             Clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned REMW = WIDTH + 2;
  localparam int unsigned CNTW = cnt_width(WIDTH);
  localparam int unsigned CW   = REMW + SKIP_L;

  div_state_e r_state;
  div_state_e w_state_nxt;

  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_quo;
  logic [REMW-1:0]  r_rem;
  logic [REMW-1:0]  r_b1;
  logic [REMW-1:0]  r_b2;
  logic [REMW-1:0]  r_b3;
  logic [CNTW-1:0]  r_cnt;
  logic             r_sign_a;
  logic             r_sign_q;
  logic             r_lead;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_b_zero;
  logic             w_wr_any;
  logic             w_launch;
  logic             w_step;
  logic             w_finish;

  logic [SKIP_L-1:0] w_nxt_l;
  logic [SKIP_M-1:0] w_nxt_m;
  logic [SKIP_S-1:0] w_nxt_s;
  logic [CW-1:0]     w_cand_l;
  logic [CW-1:0]     w_cand_m;
  logic [CW-1:0]     w_cand_s;
  logic              w_skip_en;
  logic              w_ok_l;
  logic              w_ok_m;
  logic              w_ok_s;

  logic [REMW-1:0]  w_step_rem;
  logic [1:0]       w_step_digit;
  logic [REMW-1:0]  w_rem_nxt;
  logic [WIDTH-1:0] w_dvd_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [CNTW-1:0]  w_cnt_nxt;
  logic             w_lead_nxt;
  logic [WIDTH-1:0] w_r_mag;
  logic [WIDTH-1:0] w_q_res;
  logic [WIDTH-1:0] w_r_res;

  assign w_neg_a  = sign & A[WIDTH-1];
  assign w_neg_b  = sign & B[WIDTH-1];
  assign w_mag_a  = w_neg_a ? -A : A;
  assign w_mag_b  = w_neg_b ? -B : B;
  assign w_b_zero = (B == '0);
  assign w_wr_any = wr_hi | wr_lo;

  // Next s dividend bits (MSB-aligned), zero-padded when s exceeds WIDTH.
  assign w_nxt_l  = SKIP_L'({r_dvd, SKIP_L'(0)} >> WIDTH);
  assign w_nxt_m  = SKIP_M'({r_dvd, SKIP_M'(0)} >> WIDTH);
  assign w_nxt_s  = SKIP_S'({r_dvd, SKIP_S'(0)} >> WIDTH);
  assign w_cand_l = (CW'(r_rem) << SKIP_L) | CW'(w_nxt_l);
  assign w_cand_m = (CW'(r_rem) << SKIP_M) | CW'(w_nxt_m);
  assign w_cand_s = (CW'(r_rem) << SKIP_S) | CW'(w_nxt_s);

  // Skips only cover the leading-zero run of the quotient.
  assign w_skip_en = (EARLY_SKIP != 0) && r_lead;
  assign w_ok_l = w_skip_en && (SKIP_L <= WIDTH / 2) && (32'(r_cnt) >= SKIP_L)
                  && (w_cand_l < CW'(r_b1));
  assign w_ok_m = w_skip_en && (SKIP_M <= WIDTH / 2) && (32'(r_cnt) >= SKIP_M)
                  && (w_cand_m < CW'(r_b1));
  assign w_ok_s = w_skip_en && (SKIP_S <= WIDTH / 2) && (32'(r_cnt) >= SKIP_S)
                  && (w_cand_s < CW'(r_b1));

  div_radix4_step #(
    .REMW (REMW)
  ) u_step (
    .i_rem     (r_rem),
    .i_bits    (r_dvd[WIDTH-1 -: 2]),
    .i_b1      (r_b1),
    .i_b2      (r_b2),
    .i_b3      (r_b3),
    .o_rem_c   (w_step_rem),
    .o_digit_c (w_step_digit)
  );

  // Datapath next values for one iteration: widest legal skip, else radix-4.
  always_comb begin
    w_rem_nxt  = r_rem;
    w_dvd_nxt  = r_dvd;
    w_quo_nxt  = r_quo;
    w_cnt_nxt  = r_cnt;
    w_lead_nxt = r_lead;
    if (w_ok_l) begin
      w_rem_nxt = REMW'(w_cand_l);
      w_dvd_nxt = r_dvd << SKIP_L;
      w_quo_nxt = r_quo << SKIP_L;
      w_cnt_nxt = r_cnt - CNTW'(SKIP_L);
    end else if (w_ok_m) begin
      w_rem_nxt = REMW'(w_cand_m);
      w_dvd_nxt = r_dvd << SKIP_M;
      w_quo_nxt = r_quo << SKIP_M;
      w_cnt_nxt = r_cnt - CNTW'(SKIP_M);
    end else if (w_ok_s) begin
      w_rem_nxt = REMW'(w_cand_s);
      w_dvd_nxt = r_dvd << SKIP_S;
      w_quo_nxt = r_quo << SKIP_S;
      w_cnt_nxt = r_cnt - CNTW'(SKIP_S);
    end else begin
      w_rem_nxt  = w_step_rem;
      w_dvd_nxt  = r_dvd << 2;
      w_quo_nxt  = WIDTH'({r_quo, w_step_digit});
      w_cnt_nxt  = r_cnt - CNTW'(2);
      w_lead_nxt = r_lead & (w_step_digit == 2'd0);
    end
  end

  // Sign fix-up: quotient follows A^B, remainder follows the dividend.
  assign w_r_mag = WIDTH'(w_rem_nxt);
  assign w_q_res = r_sign_q ? -w_quo_nxt : w_quo_nxt;
  assign w_r_res = r_sign_a ? -w_r_mag : w_r_mag;

  // State register.
  always_ff @(posedge Clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and control strobes; flush and MTHI/MTLO cancel work in flight.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !flush) begin
          w_launch    = 1'b1;
          w_state_nxt = w_b_zero ? DONE : ITER;
        end
      end
      ITER: begin
        if (flush || w_wr_any) begin
          w_state_nxt = IDLE;
        end else begin
          w_step = 1'b1;
          if (w_cnt_nxt == '0) begin
            w_finish    = 1'b1;
            w_state_nxt = DONE;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand latch at launch and per-iteration datapath update.
  always_ff @(posedge Clk) begin
    if (!resetn) begin
      r_dvd    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_b1     <= '0;
      r_b2     <= '0;
      r_b3     <= '0;
      r_cnt    <= '0;
      r_sign_a <= 1'b0;
      r_sign_q <= 1'b0;
      r_lead   <= 1'b0;
    end else if (w_launch) begin
      r_dvd    <= w_mag_a;
      r_quo    <= '0;
      r_rem    <= '0;
      r_b1     <= REMW'(w_mag_b);
      r_b2     <= REMW'({w_mag_b, 1'b0});
      r_b3     <= REMW'(w_mag_b) + REMW'({w_mag_b, 1'b0});
      r_cnt    <= CNTW'(WIDTH);
      r_sign_a <= w_neg_a;
      r_sign_q <= w_neg_a ^ w_neg_b;
      r_lead   <= 1'b1;
    end else if (w_step) begin
      r_dvd  <= w_dvd_nxt;
      r_quo  <= w_quo_nxt;
      r_rem  <= w_rem_nxt;
      r_cnt  <= w_cnt_nxt;
      r_lead <= w_lead_nxt;
    end
  end

  // Status flags and HI/LO; an MTHI/MTLO write wins over a result load.
  always_ff @(posedge Clk) begin
    if (!resetn) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_busy <= (w_state_nxt == ITER);
      r_done <= (w_state_nxt == DONE);
      if (w_launch) r_dz <= w_b_zero;
      if (wr_hi)                   r_hi <= wr_data;
      else if (w_launch && w_b_zero) r_hi <= A;
      else if (w_finish)           r_hi <= w_r_res;
      if (wr_lo)                   r_lo <= wr_data;
      else if (w_launch && w_b_zero) r_lo <= '1;
      else if (w_finish)           r_lo <= w_q_res;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
